score_bcd_conv: RTL and testbench



---
 rtl/score_bcd_conv_pkg.sv | 29 ++
 rtl/score_bcd_conv_if.sv | 34 +++
 rtl/score_bcd_conv_digit_adj.sv | 16 +
 rtl/score_bcd_conv.sv | 160 ++++++++++++++++
 tb/tb_score_bcd_conv.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_bcd_conv_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the score binary-to-BCD converter.
//   SCORE_WIDTH  : binary score width (also the double-dabble iteration count)
//   SCORE_DIGITS : number of packed BCD digits produced
//   bcd_digit_t  : one 4-bit BCD digit
//   conv_state_t : converter FSM states
//   cnt_width()  : iteration-counter width for a given binary width
// -----------------------------------------------------------------------------
package score_pkg;

    localparam int SCORE_WIDTH  = 16;
    localparam int SCORE_DIGITS = 5;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int SCORE_CNT_W = cnt_width(SCORE_WIDTH);

endpackage

// File: rtl/score_bcd_conv_if.sv
// -----------------------------------------------------------------------------
// score_bcd_conv_if
// Request/result bundle between the score counter side and the converter.
//   start     : pulse, sample score and request a conversion
//   score     : binary score snapshot
//   busy      : conversion in progress (including the result cycle)
//   bcd_valid : one-cycle pulse, bcd holds a new result
//   bcd       : packed BCD, digit 0 (ones) in bcd[3:0]
//   blank     : leading-zero blank mask, 1 = blank
// Modports: master drives the request, slave (the converter) drives results.
// -----------------------------------------------------------------------------
interface score_bcd_conv_if
    import score_pkg::*;
#(
    parameter int WIDTH  = SCORE_WIDTH,
    parameter int DIGITS = SCORE_DIGITS
);
    logic                  start;
    logic [WIDTH-1:0]      score;
    logic                  busy;
    logic                  bcd_valid;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, score,
        input  busy, bcd_valid, bcd, blank
    );

    modport slave (
        input  start, score,
        output busy, bcd_valid, bcd, blank
    );
endinterface

// File: rtl/score_bcd_conv_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction for one BCD digit: add 3 when the
// digit is 5 or more, so the following left shift carries into the next digit.
//   din  : current digit
//   dout : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import score_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);
    // A digit >= 5 becomes at most 12, so the sum always fits in 4 bits.
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/score_bcd_conv.sv
// -----------------------------------------------------------------------------
// score_bcd_conv
// Sequential double-dabble converter: turns a binary score snapshot into
// packed BCD, one bit per clock. A start while busy is remembered one-deep
// (newest wins) and restarts straight out of the result cycle.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : score_bcd_conv_if.slave (start/score in; busy/bcd_valid/bcd/blank out)
// Build option: define SCORE_BCD_BLANK_EN to produce the leading-zero blank
// mask; otherwise blank is tied to zero.
// -----------------------------------------------------------------------------
module score_bcd_conv
    import score_pkg::*;
#(
    parameter int WIDTH  = SCORE_WIDTH,
    parameter int DIGITS = SCORE_DIGITS
)(
    input  logic                 clk,
    input  logic                 rst,
    score_bcd_conv_if.slave      bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int BCD_W = 4 * DIGITS;

    // DIGITS must be able to hold the largest binary score.
    if (64'd10 ** DIGITS <= (64'd1 << WIDTH) - 64'd1) begin : g_digits_chk
        $error("score_bcd_conv: DIGITS too small for WIDTH");
    end

    conv_state_t        state, state_nxt;
    logic [BCD_W-1:0]   work, work_adj, work_nxt;
    logic [WIDTH-1:0]   bin, bin_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               pending;
    logic [WIDTH-1:0]   pend_score;
    logic [BCD_W-1:0]   bcd_q;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic               finish;

    // Per-digit add-3 correction ahead of the shift.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work[4*i +: 4]),
            .dout (work_adj[4*i +: 4])
        );
    end

    assign {work_nxt, bin_nxt} = {work_adj, bin} << 1;

    // Next-state and control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        load      = 1'b0;
        load_val  = bus.score;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A start arriving in this very cycle is the newest request,
                // so it takes priority over the older pending one.
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = CONV;
                end else if (pending) begin
                    load      = 1'b1;
                    load_val  = pend_score;
                    state_nxt = CONV;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            work       <= '0;
            bin        <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            pend_score <= '0;
            bcd_q      <= '0;
        end else begin
            state <= state_nxt;

            if (load) begin
                work <= '0;
                bin  <= load_val;
                cnt  <= '0;
            end else if (state == CONV) begin
                work <= work_nxt;
                bin  <= bin_nxt;
                cnt  <= cnt + CNT_W'(1);
            end

            if (finish) begin
                bcd_q <= work_nxt;
            end

            if (load) begin
                pending <= 1'b0;
            end else if (bus.start && state != IDLE) begin
                pending    <= 1'b1;
                pend_score <= bus.score;
            end
        end
    end

`ifdef SCORE_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic [DIGITS-1:0] blank_q;
    logic              zero_run;

    // Walk down from the top digit; a digit is blank while everything above
    // it (and itself) is zero. The ones digit is never blanked.
    always_comb begin
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (work_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= '0;
        end else if (finish) begin
            blank_q <= blank_nxt;
        end
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.bcd_valid = (state == DONE);
    assign bus.bcd       = bcd_q;

endmodule

// File: tb/tb_score_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_score_bcd_conv
// Self-checking bench for score_bcd_conv. A transaction-level model decides,
// cycle by cycle, when the converter is busy, when a result appears and which
// score it belongs to; expected digits come from plain decimal arithmetic.
// -----------------------------------------------------------------------------
module tb_score_bcd_conv;
    import score_pkg::*;

    localparam int WIDTH  = SCORE_WIDTH;
    localparam int DIGITS = SCORE_DIGITS;
    localparam int LAT    = WIDTH + 1;
    localparam int MAXC   = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_bcd_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    score_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit                  start_at  [MAXC];
    logic [WIDTH-1:0]    start_val [MAXC];
    logic [4*DIGITS-1:0] held_bcd;
    logic [DIGITS-1:0]   held_blank;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned s);
        logic [4*DIGITS-1:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((s / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] to_blank(input int unsigned s);
        logic [DIGITS-1:0] r;
        int unsigned p;
        r = '0;
        p = 10;
`ifdef SCORE_BCD_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (s < p);
            p = p * 10;
        end
`endif
        return r;
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            start_at[c]  = 1'b0;
            start_val[c] = '0;
        end
    endtask

    // Cycle c: sample outputs at the negedge inside cycle c, then drive the
    // inputs the DUT samples at the posedge ending cycle c.
    task automatic run_scenario(input int n, input string name);
        bit               active;
        bit               pend;
        int               done;
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] pv;
        bit               exp_busy;
        bit               exp_valid;
        active = 1'b0;
        pend   = 1'b0;
        done   = -1;
        cur    = '0;
        pv     = '0;
        for (int c = 0; c < n; c++) begin
            exp_busy  = active;
            exp_valid = active && (c == done);
            if (exp_valid) begin
                held_bcd   = to_bcd(32'(cur));
                held_blank = to_blank(32'(cur));
                if (start_at[c]) begin
                    cur  = start_val[c];
                    done = c + LAT;
                    pend = 1'b0;
                end else if (pend) begin
                    cur  = pv;
                    done = c + LAT;
                    pend = 1'b0;
                end else begin
                    active = 1'b0;
                end
            end else if (active) begin
                if (start_at[c]) begin
                    pend = 1'b1;
                    pv   = start_val[c];
                end
            end else if (start_at[c]) begin
                active = 1'b1;
                cur    = start_val[c];
                done   = c + LAT;
            end

            @(negedge clk);
            checks++;
            if (bus.busy !== exp_busy) begin
                failures++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, c, bus.busy, exp_busy);
            end
            checks++;
            if (bus.bcd_valid !== exp_valid) begin
                failures++;
                $display("FAIL %s bcd_valid cyc=%0d got=%b exp=%b", name, c, bus.bcd_valid, exp_valid);
            end
            checks++;
            if (bus.bcd !== held_bcd) begin
                failures++;
                $display("FAIL %s bcd cyc=%0d got=%h exp=%h", name, c, bus.bcd, held_bcd);
            end
            checks++;
            if (bus.blank !== held_blank) begin
                failures++;
                $display("FAIL %s blank cyc=%0d got=%b exp=%b", name, c, bus.blank, held_blank);
            end

            bus.start = start_at[c];
            bus.score = start_at[c] ? start_val[c] : WIDTH'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.score = 16'd1234;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.bcd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", bus.bcd_valid);
        end
        checks++;
        if (bus.bcd !== '0) begin
            failures++;
            $display("FAIL reset_bcd got=%h exp=0", bus.bcd);
        end
        checks++;
        if (bus.blank !== '0) begin
            failures++;
            $display("FAIL reset_blank got=%b exp=0", bus.blank);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_wins_over_start busy got=%b exp=0", bus.busy);
        end
        held_bcd   = '0;
        held_blank = '0;
    endtask

    task automatic test_single(input logic [WIDTH-1:0] s, input int n, input string name);
        clear_stim();
        start_at[0]  = 1'b1;
        start_val[0] = s;
        run_scenario(n, name);
    endtask

    task automatic test_pending();
        clear_stim();
        start_at[0] = 1'b1; start_val[0] = 16'd42;
        start_at[5] = 1'b1; start_val[5] = 16'd7;
        start_at[9] = 1'b1; start_val[9] = 16'd99;
        run_scenario(45, "pending");
    endtask

    task automatic test_back_to_back();
        clear_stim();
        start_at[0]  = 1'b1; start_val[0]  = 16'd8191;
        start_at[17] = 1'b1; start_val[17] = 16'd305;
        run_scenario(45, "back_to_back");
    endtask

    task automatic test_reset_abort();
        bus.start = 1'b1;
        bus.score = 16'd500;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if (bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL abort_busy_before cyc=%0d got=%b exp=1", c, bus.busy);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        held_bcd   = '0;
        held_blank = '0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.bcd !== '0) begin
            failures++;
            $display("FAIL abort_bcd got=%h exp=0", bus.bcd);
        end
        checks++;
        if (bus.blank !== '0) begin
            failures++;
            $display("FAIL abort_blank got=%b exp=0", bus.blank);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (bus.bcd_valid !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet cyc=%0d valid=%b busy=%b exp=0/0", c, bus.bcd_valid, bus.busy);
            end
        end
        test_single(16'd3, 25, "after_abort");
    endtask

    task automatic test_random(input int round);
        clear_stim();
        start_at[0]  = 1'b1;
        start_val[0] = WIDTH'($urandom);
        for (int c = 1; c < 50; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                start_at[c]  = 1'b1;
                start_val[c] = WIDTH'($urandom);
            end
        end
        run_scenario(MAXC, $sformatf("random%0d", round));
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.score  = '0;
        held_bcd   = '0;
        held_blank = '0;
        test_reset();
        test_single(16'd0, 25, "zero");
        test_single(16'd1234, 40, "score_1234");
        test_single(16'd65535, 25, "max");
        test_pending();
        test_back_to_back();
        test_reset_abort();
        for (int r = 0; r < 3; r++) begin
            test_random(r);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
